epidemic_port_arbiter: RTL

- Output-port scheduler for one direction (l/r/t/b) of the epidemic-routing mesh node.
- Shares a single outgoing 8-bit ready/valid link between N requesters: the other input directions plus local inject.
- Round-robin fairness; one-entry registered output stage.
- Performs the epidemic hop-count (TTL) decrement and drops expired flits instead of forwarding them.

---
 rtl/epidemic_port_arbiter_if.sv | 18 +
 rtl/epidemic_port_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/epidemic_port_arbiter_if.sv
// Output-link bundle of one epidemic port: N requesters in, one ready/valid link out.
interface epidemic_port_arbiter_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8
);
    logic [N-1:0]        i_valid;
    logic [N-1:0]        o_ready;
    logic [N*DATA_W-1:0] i_data;
    logic                o_valid;
    logic                i_ready;
    logic [DATA_W-1:0]   o_data;
    logic [N-1:0]        o_grant;

    modport slave  (input  i_valid, i_data, i_ready,
                    output o_ready, o_valid, o_data, o_grant);
    modport master (output i_valid, i_data, i_ready,
                    input  o_ready, o_valid, o_data, o_grant);
endinterface

// File: rtl/epidemic_port_arbiter.sv
// Round-robin output-port scheduler with TTL decrement and expired-flit drop.
// One registered output stage; o_ready is the only combinational path (via i_ready).
module epidemic_port_lane #(
    parameter int DATA_W = 8,
    parameter int HOP_W  = 3
) (
    input  logic [DATA_W-1:0] flit,
    output logic              expired,
    output logic [DATA_W-1:0] next_flit
);
    logic [HOP_W-1:0] hop;

    assign hop       = flit[DATA_W-1 -: HOP_W];
    assign expired   = (hop == '0);
    // only used when !expired, so the decrement never wraps
    assign next_flit = {hop - HOP_W'(1), flit[DATA_W-HOP_W-1:0]};
endmodule

module epidemic_port_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int HOP_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    epidemic_port_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]        o_drop_cnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]             ptr;
    logic                      valid_q;
    logic [DATA_W-1:0]         data_q;
    logic [N-1:0]              grant_q;

    logic [N-1:0]              expired;
    logic [N-1:0][DATA_W-1:0]  next_flit;
    logic                      can_load;
    logic                      any_req;
    logic [PW-1:0]             gnt_idx;
    logic [PW-1:0]             ptr_nxt;
    logic [PW:0]               sum;

    for (genvar k = 0; k < N; k++) begin : g_lane
        epidemic_port_lane #(.DATA_W(DATA_W), .HOP_W(HOP_W)) u_lane (
            .flit      (bus.i_data[k*DATA_W +: DATA_W]),
            .expired   (expired[k]),
            .next_flit (next_flit[k])
        );
    end

    assign can_load = !valid_q || bus.i_ready;

    // first valid requester scanning from ptr upward with wrap
    always_comb begin
        any_req = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (PW+1)'(off);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            if (!any_req && bus.i_valid[sum[PW-1:0]]) begin
                any_req = 1'b1;
                gnt_idx = sum[PW-1:0];
            end
        end
    end

    assign ptr_nxt = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);

    always_comb begin
        bus.o_ready = '0;
        if (can_load && any_req) bus.o_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            grant_q    <= '0;
            o_drop_cnt <= '0;
        end else if (can_load) begin
            if (any_req) begin
                ptr     <= ptr_nxt;
                grant_q <= N'(1) << gnt_idx;
                if (expired[gnt_idx]) begin
                    valid_q <= 1'b0;
                    if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + CNT_W'(1);
                end else begin
                    valid_q <= 1'b1;
                    data_q  <= next_flit[gnt_idx];
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_grant = grant_q;
endmodule
